// File: rtl/id_sequencer.sv
// Producer side of the control-ID interface: accepts decoded IDs, stretches
// multi-cycle operations, flushes on taken branches and parks in halt.
module id_sequencer #(
  parameter int ID_WIDTH     = 7,
  parameter int MEM_WAIT     = 2,
  parameter int RESET_CYCLES = 2,
  parameter int NOP_ID       = 74,
  parameter int HALT_ID      = 75
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [ID_WIDTH-1:0] instr_id,
  output logic                instr_ready,
  input  logic                take,
  input  logic                io_confirm,
  output logic [ID_WIDTH-1:0] id_out,
  output logic                pc_enable,
  output logic                flush,
  output logic                halted,
  output logic                illegal
);

  localparam int CNT_W  = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam int RST_N  = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int RST_W  = (RST_N < 2) ? 1 : $clog2(RST_N);
  localparam logic [RST_W-1:0]    RST_LAST = RST_W'(RST_N - 1);
  localparam logic [ID_WIDTH-1:0] RST_ID   = ID_WIDTH'(100);
  localparam logic [ID_WIDTH-1:0] IO_ID    = ID_WIDTH'(71);

  typedef enum logic [2:0] {
    RST, FETCH, EXEC, MEM, IOWAIT, HALT
  } state_t;

  typedef enum logic [2:0] {
    C_MEM, C_IO, C_HALT, C_SOFTRST, C_BRANCH, C_PLAIN, C_ILLEGAL
  } class_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [RST_W-1:0]    rstcnt;
  logic [ID_WIDTH-1:0] lid;
  class_t              lid_class;

  // Sorts an ID into the behaviour class that decides how EXEC proceeds.
  function automatic class_t classify(input logic [ID_WIDTH-1:0] id);
    int unsigned v;
    v = {{(32-ID_WIDTH){1'b0}}, id};
    if ((v >= 39 && v <= 55) || v == 67 || v == 68)
      return C_MEM;
    else if (v == 71)
      return C_IO;
    else if (v == 75)
      return C_HALT;
    else if (v == 100)
      return C_SOFTRST;
    else if (v == 38 || v == 72 || v == 73)
      return C_BRANCH;
    else if ((v >= 1 && v <= 37) || (v >= 56 && v <= 66) ||
             v == 69 || v == 70 || v == 74)
      return C_PLAIN;
    else
      return C_ILLEGAL;
  endfunction

  assign lid_class = classify(lid);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RST;
      cnt    <= '0;
      rstcnt <= '0;
      lid    <= '0;
    end else begin
      case (state)
        RST: begin
          if (rstcnt == RST_LAST) begin
            rstcnt <= '0;
            state  <= FETCH;
          end else begin
            rstcnt <= rstcnt + 1'b1;
          end
        end
        FETCH: begin
          if (instr_valid) begin
            lid   <= instr_id;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (lid_class)
            C_MEM: begin
              if (MEM_WAIT == 0) begin
                state <= FETCH;
              end else begin
                cnt   <= CNT_W'(MEM_WAIT);
                state <= MEM;
              end
            end
            C_IO:      state <= IOWAIT;
            C_HALT:    state <= HALT;
            C_SOFTRST: begin
              cnt    <= '0;
              rstcnt <= '0;
              state  <= RST;
            end
            default:   state <= FETCH;
          endcase
        end
        MEM: begin
          // Exit at cnt==1 so the counter never has to wrap through zero.
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FETCH;
        end
        IOWAIT: begin
          if (io_confirm)
            state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  // Outputs decode from registered state; flush and IOWAIT pc_enable also
  // look at the live take/io_confirm inputs.
  always_comb begin
    id_out      = ID_WIDTH'(NOP_ID);
    instr_ready = 1'b0;
    pc_enable   = 1'b0;
    flush       = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state)
      RST: id_out = RST_ID;
      FETCH: begin
        id_out      = ID_WIDTH'(NOP_ID);
        instr_ready = 1'b1;
      end
      EXEC: begin
        id_out = lid;
        case (lid_class)
          C_MEM:    pc_enable = (MEM_WAIT == 0);
          C_BRANCH: begin
            pc_enable = 1'b1;
            flush     = take;
          end
          C_PLAIN:  pc_enable = 1'b1;
          C_ILLEGAL: begin
            id_out    = ID_WIDTH'(NOP_ID);
            illegal   = 1'b1;
            pc_enable = 1'b1;
          end
          default:  pc_enable = 1'b0;
        endcase
      end
      MEM: begin
        id_out    = lid;
        pc_enable = (cnt == CNT_W'(1));
      end
      IOWAIT: begin
        id_out    = IO_ID;
        pc_enable = io_confirm;
      end
      HALT: begin
        id_out = ID_WIDTH'(HALT_ID);
        halted = 1'b1;
      end
      default: id_out = RST_ID;
    endcase
  end

endmodule

// File: tb/tb_id_sequencer.sv
// Directed bench for id_sequencer: each task walks one scenario cycle by
// cycle against hand-computed output vectors {id_out,ready,pc,flush,halt,ill}.
module tb_id_sequencer;

  logic       clock;
  logic       reset;
  logic       instr_valid;
  logic [6:0] instr_id;
  logic       instr_ready;
  logic       take;
  logic       io_confirm;
  logic [6:0] id_out;
  logic       pc_enable;
  logic       flush;
  logic       halted;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        v;
    logic [6:0]  id;
    logic        tk;
    logic        cf;
    logic [11:0] exp;
  } step_t;

  id_sequencer #(
    .ID_WIDTH(7), .MEM_WAIT(2), .RESET_CYCLES(2), .NOP_ID(74), .HALT_ID(75)
  ) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_id(instr_id), .instr_ready(instr_ready), .take(take),
    .io_confirm(io_confirm), .id_out(id_out), .pc_enable(pc_enable),
    .flush(flush), .halted(halted), .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [11:0] e(input int id, input logic rdy, input logic pc,
                                    input logic fl, input logic ht, input logic il);
    return {7'(id), rdy, pc, fl, ht, il};
  endfunction

  function automatic step_t st(input logic v, input int id, input logic tk,
                               input logic cf, input logic [11:0] exp);
    step_t s;
    s.v = v; s.id = 7'(id); s.tk = tk; s.cf = cf; s.exp = exp;
    return s;
  endfunction

  // Assert reset, check the reset vector, release and walk RST, RST, FETCH.
  task automatic test_reset();
    logic [11:0] obs;
    logic [11:0] want [4];
    want[0] = e(100,0,0,0,0,0);
    want[1] = e(100,0,0,0,0,0);
    want[2] = e(100,0,0,0,0,0);
    want[3] = e(74,1,0,0,0,0);
    reset = 1'b0; instr_valid = 1'b0; instr_id = '0; take = 1'b0; io_confirm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) reset = 1'b1;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== want[i]) begin
        bad++;
        $display("[TB] FAIL reset step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], want[i][11:5], want[i][4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_single();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 4, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(4,0,1,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL single step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_mem();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 44, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(44,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(44,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(44,0,1,0,0,0)));
    q.push_back(st(1, 67, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(67,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(67,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(67,0,1,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL mem step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_branch();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 73, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 1, 0, e(73,0,1,1,0,0)));
    q.push_back(st(1, 73, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(73,0,1,0,0,0)));
    q.push_back(st(1, 38, 1, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 1, 0, e(38,0,1,1,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL branch step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_iowait();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 71, 0, 0, e(74,1,0,0,0,0)));
    for (int k = 0; k < 5; k++) q.push_back(st(0, 0, 0, 0, e(71,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 1, e(71,0,1,0,0,0)));
    q.push_back(st(1, 71, 0, 1, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 1, e(71,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 1, e(71,0,1,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL iowait step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_illegal();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 90, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,0,1,0,0,1)));
    q.push_back(st(1, 0, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,0,1,0,0,1)));
    q.push_back(st(1, 127, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,0,1,0,0,1)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL illegal step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_soft_reset();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 100, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(100,0,0,0,0,0)));
    q.push_back(st(1, 5, 0, 0, e(100,0,0,0,0,0)));
    q.push_back(st(1, 5, 0, 0, e(100,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL softreset step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  // Valid held high across EXEC must not be accepted until FETCH returns.
  task automatic test_back_to_back();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 5, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(1, 60, 0, 0, e(5,0,1,0,0,0)));
    q.push_back(st(1, 60, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(1, 69, 0, 0, e(60,0,1,0,0,0)));
    q.push_back(st(1, 69, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(69,0,1,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(74,1,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL b2b step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_halt();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 75, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(1, 75, 0, 0, e(75,0,0,0,0,0)));
    for (int k = 0; k < 4; k++) q.push_back(st(1, 4, 0, 1, e(75,0,0,0,1,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL halt step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
    instr_valid = 1'b0; io_confirm = 1'b0;
    #1 reset = 1'b0;
    #1;
    obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
    total++;
    if (obs !== e(100,0,0,0,0,0)) begin
      bad++;
      $display("[TB] FAIL halt_async_reset: got id=%0d flags=%b want id=100 flags=00000",
               obs[11:5], obs[4:0]);
    end
    @(posedge clock); #1;
    test_reset();
  endtask

  // Reset in the final MEM cycle must abort without a late pc_enable.
  task automatic test_reset_mid_mem();
    step_t q[$];
    logic [11:0] obs;
    q.push_back(st(1, 50, 0, 0, e(74,1,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(50,0,0,0,0,0)));
    q.push_back(st(0, 0, 0, 0, e(50,0,0,0,0,0)));
    foreach (q[i]) begin
      instr_valid = q[i].v; instr_id = q[i].id; take = q[i].tk; io_confirm = q[i].cf;
      #1;
      obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("[TB] FAIL midmem step %0d: got id=%0d flags=%b want id=%0d flags=%b",
                 i, obs[11:5], obs[4:0], q[i].exp[11:5], q[i].exp[4:0]);
      end
      @(posedge clock); #1;
    end
    #1;
    obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
    total++;
    if (obs !== e(50,0,1,0,0,0)) begin
      bad++;
      $display("[TB] FAIL midmem_cnt1: got id=%0d flags=%b want id=50 flags=01000",
               obs[11:5], obs[4:0]);
    end
    reset = 1'b0;
    #1;
    obs = {id_out, instr_ready, pc_enable, flush, halted, illegal};
    total++;
    if (obs !== e(100,0,0,0,0,0)) begin
      bad++;
      $display("[TB] FAIL midmem_async_reset: got id=%0d flags=%b want id=100 flags=00000",
               obs[11:5], obs[4:0]);
    end
    @(posedge clock); #1;
    test_reset();
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr_id = '0; take = 1'b0; io_confirm = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_single();
    test_mem();
    test_branch();
    test_iowait();
    test_illegal();
    test_soft_reset();
    test_back_to_back();
    test_halt();
    test_reset_mid_mem();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
